// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg -- shared types and constants for the ADC emulator.
//   state_t           : controller states (idle, converting, data ready)
//   CFG_HEADER        : header a config frame must carry to be committed
//   CFG_BITS_DEFAULT  : default config frame length (2-bit header + payload)
//   CFG_PAYLOAD_BITS  : width of the committed control word
//   EDGE_CNT_BITS/MAX : width and saturation value of the scka rise counter
package adc_emu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    localparam logic [1:0] CFG_HEADER       = 2'b10;
    localparam int         CFG_BITS_DEFAULT = 12;
    localparam int         CFG_PAYLOAD_BITS = 10;
    localparam int         EDGE_CNT_BITS    = 6;
    localparam logic [EDGE_CNT_BITS-1:0] EDGE_CNT_MAX = 6'd63;

endpackage

// File: rtl/adc_emu_shreg.sv
// adc_emu_shreg -- loadable MSB-first shift register with zero fill.
//   clk, arstn : clock, asynchronous active-low reset (register clears to 0)
//   load       : parallel load from value (wins over shift_en)
//   value      : parallel load data
//   shift_en   : shift left by one, LSB filled with 0
//   msb        : current MSB, i.e. the serial output bit
module adc_emu_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             shift_en,
    output logic             msb
);

    logic [WIDTH-1:0] data;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            data <= '0;
        end else if (load) begin
            data <= value;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = data[WIDTH-1];

endmodule

// File: rtl/adc_emu.sv
// adc_emu -- behavioural emulator of a dual-channel SAR ADC with serial
// readout and a serial configuration port.
//   clk, arstn      : clock (all logic on posedge), async active-low reset
//   mclk            : conversion start; a rising level starts a conversion
//   scka, sdi       : serial clock / config data from the master
//   sync            : readout restart while data is ready
//   din_a, din_b    : sample values presented as the conversion result
//   busy            : high for exactly CONV_CYCLES cycles per conversion
//   drl             : low while a sample is available for readout
//   sdoa, sdob      : serial data of channels A/B, MSB first, shifted on scka fall
//   cfg_word        : last committed control payload
//   cfg_valid       : one-cycle pulse when cfg_word is updated
//   overrun         : one-cycle pulse when mclk rises during a conversion
// Build option: define ADC_EMU_PATTERN_EN to add the internal ramp source,
// selected by cfg_word[0] (A = conversion index, B = ~A).
import adc_emu_pkg::*;

module adc_emu #(
    parameter int CONV_CYCLES = 20,
    parameter int WORD_BITS   = 32,
    parameter int CFG_BITS    = CFG_BITS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        mclk,
    input  logic                        scka,
    input  logic                        sdi,
    input  logic                        sync,
    input  logic [WORD_BITS-1:0]        din_a,
    input  logic [WORD_BITS-1:0]        din_b,
    output logic                        busy,
    output logic                        drl,
    output logic                        sdoa,
    output logic                        sdob,
    output logic [CFG_PAYLOAD_BITS-1:0] cfg_word,
    output logic                        cfg_valid,
    output logic                        overrun
);

    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W  = $clog2(WORD_BITS + 1);
    localparam logic [CONV_W-1:0]        CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0]         BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [EDGE_CNT_BITS-1:0] CFG_EDGES = EDGE_CNT_BITS'(CFG_BITS);

    state_t                     state, state_nxt;
    logic                       mclk_q, scka_q;
    logic [CONV_W-1:0]          conv_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic [EDGE_CNT_BITS-1:0]   edge_cnt;
    logic [CFG_BITS-1:0]        frame;
    logic [WORD_BITS-1:0]       sample_a, sample_b;
    logic [WORD_BITS-1:0]       src_a, src_b;

    logic mclk_rise, scka_rise, scka_fall;
    logic start_conv, latch, reload, shift_en, overrun_set, cfg_commit;

    assign mclk_rise = mclk & ~mclk_q;
    assign scka_rise = scka & ~scka_q;
    assign scka_fall = ~scka & scka_q;

`ifdef ADC_EMU_PATTERN_EN
    logic [WORD_BITS-1:0] conv_idx;

    // Ramp index advances once per completed conversion and wraps naturally.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            conv_idx <= '0;
        end else if (latch) begin
            conv_idx <= conv_idx + 1'b1;
        end
    end

    assign src_a = cfg_word[0] ? conv_idx  : din_a;
    assign src_b = cfg_word[0] ? ~conv_idx : din_b;
`else
    assign src_a = din_a;
    assign src_b = din_b;
`endif

    // Next-state and control strobes. In READY a new conversion beats a
    // readout restart, which beats a shift.
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt   = state;
        start_conv  = 1'b0;
        latch       = 1'b0;
        reload      = 1'b0;
        shift_en    = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mclk_rise) begin
                    start_conv = 1'b1;
                    state_nxt  = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                overrun_set = mclk_rise;
                if (conv_cnt == CONV_LAST) begin
                    latch     = 1'b1;
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (mclk_rise) begin
                    start_conv = 1'b1;
                    state_nxt  = ST_CONVERT;
                end else if (sync) begin
                    reload = 1'b1;
                end else if (scka_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config commits only on an accepted start and only for a frame of exactly
    // CFG_BITS rises, so 32-edge readouts never masquerade as config.
    assign cfg_commit = start_conv && (edge_cnt == CFG_EDGES)
                        && (frame[CFG_BITS-1 -: 2] == CFG_HEADER);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            mclk_q    <= 1'b0;
            scka_q    <= 1'b0;
            conv_cnt  <= '0;
            bit_cnt   <= '0;
            edge_cnt  <= '0;
            frame     <= '0;
            sample_a  <= '0;
            sample_b  <= '0;
            cfg_word  <= '0;
            cfg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mclk_q    <= mclk;
            scka_q    <= scka;
            cfg_valid <= cfg_commit;
            overrun   <= overrun_set;

            if (start_conv) begin
                conv_cnt <= '0;
            end else if (state == ST_CONVERT) begin
                conv_cnt <= conv_cnt + 1'b1;
            end

            if (latch) begin
                sample_a <= src_a;
                sample_b <= src_b;
            end

            if (latch || reload) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (scka_rise) begin
                frame <= {frame[CFG_BITS-2:0], sdi};
            end

            if (start_conv) begin
                edge_cnt <= '0;
            end else if (scka_rise && (edge_cnt != EDGE_CNT_MAX)) begin
                edge_cnt <= edge_cnt + 1'b1;
            end

            if (cfg_commit) begin
                cfg_word <= frame[CFG_PAYLOAD_BITS-1:0];
            end
        end
    end

    // A fresh conversion loads the new sample; sync replays the stored one.
    adc_emu_shreg #(.WIDTH(WORD_BITS)) u_shreg_a (
        .clk      (clk),
        .arstn    (arstn),
        .load     (latch | reload),
        .value    (latch ? src_a : sample_a),
        .shift_en (shift_en),
        .msb      (sdoa)
    );

    adc_emu_shreg #(.WIDTH(WORD_BITS)) u_shreg_b (
        .clk      (clk),
        .arstn    (arstn),
        .load     (latch | reload),
        .value    (latch ? src_b : sample_b),
        .shift_en (shift_en),
        .msb      (sdob)
    );

    assign busy = (state == ST_CONVERT);
    assign drl  = (state != ST_READY);

endmodule

// File: doc/adc_emu.md
ADC_EMU -- requirements
Module: adc_emu

Interface
REQ-001 Parameter CONV_CYCLES, default 20: clk cycles busy stays high per conversion.
REQ-002 Parameter WORD_BITS, default 32: readout word length per channel.
REQ-003 Parameter CFG_BITS, default 12: config frame length, 2-bit header plus 10-bit payload.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 arstn  input  1  asynchronous active-low reset.
REQ-006 mclk  input  1  conversion start from master, sampled in clk domain.
REQ-007 scka  input  1  serial clock from master.
REQ-008 sdi  input  1  config data from master.
REQ-009 sync  input  1  readout-start pulse from master.
REQ-010 busy  output  1  conversion in progress.
REQ-011 drl  output  1  low = data ready for readout.
REQ-012 sdoa  output  1  channel A serial data, MSB first.
REQ-013 sdob  output  1  channel B serial data, MSB first.
REQ-014 din_a, din_b  input  WORD_BITS each  sample values to emulate.
REQ-015 cfg_word  output  10  last accepted control payload.
REQ-016 cfg_valid  output  1  one-cycle pulse on cfg_word update.
REQ-017 overrun  output  1  one-cycle pulse when mclk rises during busy.

Function
REQ-018 mclk rise = mclk high this cycle, low previous cycle; scka rise/fall detected the same way from a registered copy.
REQ-019 States: IDLE, CONVERT, READY.
REQ-020 IDLE or READY + mclk rise -> CONVERT next cycle: busy=1, drl=1, conversion counter cleared, scka edge counter cleared.
REQ-021 CONVERT: busy held exactly CONV_CYCLES cycles; on final cycle din_a/din_b latched into shift registers A/B, busy=0, drl=0, state READY.
REQ-022 mclk rise in CONVERT ignored, overrun pulses, conversion not restarted.
REQ-023 sdoa/sdob = MSB of shift registers; valid from the cycle drl falls, hence stable before next scka rise.
REQ-024 READY: each scka fall shifts both registers left by one, zero fill; after WORD_BITS falls drl returns 1, state IDLE.
REQ-025 sync high in READY reloads shift registers from latched sample and clears bit counter (readout restart); ignored elsewhere.
REQ-026 sdi sampled into CFG_BITS shift register on every scka rise, any state; edge counter saturates at 63.
REQ-027 On mclk rise, if edge counter == CFG_BITS and frame[11:10] == 2'b10: cfg_word <= frame[9:0], cfg_valid pulses same cycle busy rises; otherwise cfg_word unchanged.
REQ-028 32-edge readouts never commit config (count mismatch); scka activity during CONVERT is counted toward config framing.
REQ-029 Simultaneous mclk rise and final scka fall in READY: mclk wins, state CONVERT, drl=1.

Reset
REQ-030 arstn low: state IDLE, busy=0, drl=1, sdoa=sdob=0, shift registers 0, cfg_word=0, cfg_valid=0, overrun=0, counters 0.
REQ-031 Reset mid-conversion or mid-readout aborts immediately; first mclk rise after release starts a fresh conversion.

Configuration
REQ-032 Macro ADC_EMU_PATTERN_EN defined: cfg_word[0]=1 selects internal ramp (A = conversion index, B = bitwise inverse of A, index increments per completed conversion, wraps at 2^WORD_BITS); cfg_word[0]=0 selects din_a/din_b.
REQ-033 Macro undefined: ramp logic absent, din_a/din_b always used, cfg_word[0] has no data effect.

Structure
REQ-034 Package adc_emu_pkg holds the state enum type and constants CFG_HEADER=2'b10 and CFG_BITS default.
REQ-035 One sub-module adc_emu_shreg (loadable MSB-first shift register, shift on enable), instantiated for A and B.

Verification
REQ-036 din_a=32'hDEADBEEF, din_b=32'h12345678, mclk pulse -> busy high 20 cycles, drl falls; 32 scka pulses reproduce both words MSB first.
REQ-037 Send 12-bit frame 10_0101010101 after busy falls, then mclk -> cfg_word=10'h155, single cfg_valid pulse.
REQ-038 Frame header 01 or 11 edges -> cfg_word unchanged, no cfg_valid.
REQ-039 Second mclk pulse 5 cycles into CONVERT -> overrun pulse, busy still falls 20 cycles after first.
REQ-040 Readout aborted after 10 bits by mclk -> drl=1, busy=1 next cycle; next readout returns new sample.
REQ-041 With ADC_EMU_PATTERN_EN and cfg_word[0]=1 -> successive reads give A=0,1,2, B=FFFFFFFF,FFFFFFFE,FFFFFFFD.
